// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receive side of a multiplexed 7-segment bus; rebuilds 4-digit hex frames.
// Latency: pair stable at synchronizer output -> digit stored STABLE_CYCLES+1 clk; last digit -> frame_valid 1 clk.
// Backpressure: none; the bus is free-running and frames are published as 1-cycle pulses.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   seg_in[6:0]      active-low segments, [6]=a .. [0]=g (asynchronous to clk)
//   an_in[3:0]       active-low one-hot anode selects, [0]=digit0 (asynchronous to clk)
//   digits[15:0]     last complete frame, digit i at [4i+3:4i]
//   frame_valid      1-cycle pulse when digits updates
//   pat_err, an_err  sticky error flags, cleared by the next frame publication
//   stale            no digit accepted for TIMEOUT_CYCLES clocks
//   frame_cnt/err_cnt  statistics, present only with SEG7_CAP_STATS_EN defined
module seg7_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        an_err,
`ifdef SEG7_CAP_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
`endif
  output logic        stale
);

  localparam logic [7:0]  ST_MAX = 8'(STABLE_CYCLES);
  localparam logic [19:0] TO_MAX = 20'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_SCAN, S_SETTLE, S_ACCEPT, S_HOLD} state_t;

  // Two-flop synchronizers, reset to the idle (all-off) bus level.
  logic [6:0]  r_seg_s1, r_seg_s2;
  logic [3:0]  r_an_s1, r_an_s2;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_pair;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        w_latch;

  logic [15:0] r_buf;
  logic [3:0]  r_seen;
  logic [15:0] r_digits;
  logic        r_frame_valid;
  logic        r_pat_err, r_an_err;
  logic [19:0] r_to;

  logic [10:0] w_pair;
  logic        w_chg;
  logic [6:0]  w_seg;
  logic [3:0]  w_an_low;
  logic        w_acc_dig, w_acc_anerr, w_pat_set;
  logic [3:0]  w_nib;
  logic        w_bad;
  logic        w_frame;

  assign w_pair   = {r_seg_s2, r_an_s2};
  assign w_chg    = (w_pair != r_pair);
  assign w_seg    = r_pair[10:4];
  assign w_an_low = ~r_pair[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_in;
      r_an_s2  <= r_an_s1;
    end
  end

  // Next-state logic. Any change of the synced pair (outside ACCEPT) restarts
  // the stability count; ACCEPT is entered on the clock that the count reaches
  // STABLE_CYCLES, so the pair has been sampled equal STABLE_CYCLES times.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      S_SCAN, S_SETTLE, S_HOLD: begin
        if (w_chg) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = (ST_MAX == 8'd1) ? S_ACCEPT : S_SETTLE;
        end else if (r_state == S_SETTLE) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == ST_MAX - 8'd1) w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: w_state_nxt = S_HOLD;
      default:  w_state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SCAN;
      r_cnt   <= '0;
      r_pair  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) r_pair <= w_pair;
    end
  end

  // Segment decode, active-low abcdefg.
  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (w_seg)
      7'h01: w_nib = 4'h0;
      7'h4F: w_nib = 4'h1;
      7'h12: w_nib = 4'h2;
      7'h06: w_nib = 4'h3;
      7'h4C: w_nib = 4'h4;
      7'h24: w_nib = 4'h5;
      7'h20: w_nib = 4'h6;
      7'h0F: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h04: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h60: w_nib = 4'hB;
      7'h31: w_nib = 4'hC;
      7'h42: w_nib = 4'hD;
      7'h30: w_nib = 4'hE;
      7'h38: w_nib = 4'hF;
      default: w_bad = 1'b1;
    endcase
  end

  // A blank sample (no anode low) falls through both terms and is ignored.
  assign w_acc_dig   = (r_state == S_ACCEPT) && $onehot(w_an_low);
  assign w_acc_anerr = (r_state == S_ACCEPT) && !$onehot0(w_an_low);
  assign w_pat_set   = w_acc_dig && w_bad;
  assign w_frame     = (r_seen == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf         <= '0;
      r_seen        <= '0;
      r_digits      <= '0;
      r_frame_valid <= 1'b0;
      r_pat_err     <= 1'b0;
      r_an_err      <= 1'b0;
      r_to          <= '0;
    end else begin
      if (w_acc_dig) begin
        for (int i = 0; i < 4; i++) begin
          if (w_an_low[i]) r_buf[4*i +: 4] <= w_bad ? 4'h0 : w_nib;
        end
      end
      // Frame publication clears seen; an accept in the same cycle still counts.
      r_seen <= (w_frame ? 4'h0 : r_seen) | (w_acc_dig ? w_an_low : 4'h0);
      r_frame_valid <= w_frame;
      if (w_frame) r_digits <= r_buf;
      // Set beats the frame-time clear.
      if (w_pat_set)    r_pat_err <= 1'b1;
      else if (w_frame) r_pat_err <= 1'b0;
      if (w_acc_anerr)  r_an_err <= 1'b1;
      else if (w_frame) r_an_err <= 1'b0;
      if (w_acc_dig)             r_to <= '0;
      else if (r_to != TO_MAX)   r_to <= r_to + 20'd1;
    end
  end

`ifdef SEG7_CAP_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_frame) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_pat_set || w_acc_anerr) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

  assign digits      = r_digits;
  assign frame_valid = r_frame_valid;
  assign pat_err     = r_pat_err;
  assign an_err      = r_an_err;
  assign stale       = (r_to == TO_MAX);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] digits;
  logic        frame_valid, pat_err, an_err, stale;
`ifdef SEG7_CAP_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int fv_cnt = 0;
  int fv_cycles = 0;
  logic fv_prev = 1'b0;
  int fv_snap;

  seg7_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .an_in(an_in),
    .digits(digits),
    .frame_valid(frame_valid),
    .pat_err(pat_err),
    .an_err(an_err),
`ifdef SEG7_CAP_STATS_EN
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt),
`endif
    .stale(stale)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cycles++;
      if (!fv_prev) fv_cnt++;
    end
    fv_prev <= (frame_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds the pair for n cycles and returns at a falling edge.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state and exact timeout boundary on an idle bus.
    repeat (3) @(negedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_pat", 32'(pat_err), 32'h0);
    check("rst_an", 32'(an_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (99) @(negedge clk);
    check("stale_at_99", 32'(stale), 32'h0);
    @(negedge clk);
    check("stale_at_100", 32'(stale), 32'h1);

    // Clean scan 1,2,3,4.
    drive(4'b1110, 7'h4F, 10);
    drive(4'b1101, 7'h12, 10);
    drive(4'b1011, 7'h06, 10);
    drive(4'b0111, 7'h4C, 10);
    drive(4'b1111, 7'h7F, 4);
    check("clean_fv_cnt", 32'(fv_cnt), 32'd1);
    check("clean_digits", 32'(digits), 32'h4321);
    check("clean_pat", 32'(pat_err), 32'h0);
    check("clean_an", 32'(an_err), 32'h0);
    check("clean_stale", 32'(stale), 32'h0);

    // Glitch: 3-cycle seg=00 inside digit0 is rejected; a 4-cycle digit1 is accepted.
    drive(4'b1110, 7'h4F, 10);
    drive(4'b1110, 7'h00, 3);
    drive(4'b1110, 7'h4F, 10);
    drive(4'b1101, 7'h06, 4);
    drive(4'b1111, 7'h7F, 6);
    drive(4'b1011, 7'h24, 10);
    drive(4'b0111, 7'h0F, 10);
    check("glitch_fv_cnt", 32'(fv_cnt), 32'd2);
    check("glitch_digits", 32'(digits), 32'h7531);
    check("glitch_pat", 32'(pat_err), 32'h0);

    // Bad pattern on digit2 and two anodes low.
    drive(4'b1110, 7'h4F, 10);
    drive(4'b1101, 7'h12, 10);
    drive(4'b1011, 7'h7F, 10);
    check("bad_pat_set", 32'(pat_err), 32'h1);
    check("bad_an_clear", 32'(an_err), 32'h0);
    drive(4'b1100, 7'h4F, 10);
    check("bad_an_set", 32'(an_err), 32'h1);
    check("bad_no_frame", 32'(fv_cnt), 32'd2);
    drive(4'b0111, 7'h4C, 10);
    check("bad_fv_cnt", 32'(fv_cnt), 32'd3);
    check("bad_digits", 32'(digits), 32'h4021);
    check("bad_pat_cleared", 32'(pat_err), 32'h0);
    check("bad_an_cleared", 32'(an_err), 32'h0);
`ifdef SEG7_CAP_STATS_EN
    check("stats_frames", 32'(frame_cnt), 32'd3);
    check("stats_errs", 32'(err_cnt), 32'd2);
`endif

    // Reset in the middle of SETTLE.
    drive(4'b1110, 7'h4F, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_fv", 32'(frame_valid), 32'h0);
    check("midrst_pat", 32'(pat_err), 32'h0);
    check("midrst_an", 32'(an_err), 32'h0);
    check("midrst_stale", 32'(stale), 32'h0);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fv_snap = fv_cnt;
    drive(4'b1110, 7'h31, 10);
    drive(4'b1101, 7'h42, 10);
    drive(4'b1011, 7'h30, 10);
    check("postrst_no_frame", 32'(fv_cnt), 32'(fv_snap));
    check("postrst_digits0", 32'(digits), 32'h0);
    drive(4'b0111, 7'h38, 10);
    check("postrst_frame", 32'(fv_cnt), 32'(fv_snap + 1));
    check("postrst_digits", 32'(digits), 32'hFEDC);

    // Remaining decode values.
    drive(4'b1110, 7'h01, 10);
    drive(4'b1101, 7'h20, 10);
    drive(4'b1011, 7'h04, 10);
    drive(4'b0111, 7'h60, 10);
    check("dec_digits", 32'(digits), 32'hB960);
    check("dec_pat", 32'(pat_err), 32'h0);
`ifdef SEG7_CAP_STATS_EN
    check("stats_after_rst", 32'(frame_cnt), 32'd2);
`endif

    // Timeout on a blank bus, cleared by one valid digit.
    drive(4'b1111, 7'h7F, 50);
    check("to_not_yet", 32'(stale), 32'h0);
    drive(4'b1111, 7'h7F, 100);
    check("to_stale", 32'(stale), 32'h1);
    drive(4'b1110, 7'h4F, 10);
    check("to_cleared", 32'(stale), 32'h0);
    check("fv_single_cycle", 32'(fv_cycles), 32'(fv_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
